// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-pacing FSM states and common timing constants.
// Imported by the receiver, sender and transmit buffer.
package uart_pkg;

    localparam int DEPTH_LOG2_DEFAULT = 4;
    localparam int CLK_PER_HALF_BIT   = 868;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count. A push while full and a pop while empty
// are ignored. The read port is a combinational view of the head entry.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            wr_data,
    input  logic                  pop,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(DEPTH_LOG2 + 1){1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage is never reset; reset only discards it by zeroing the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus pacing FSM in front of the UART sender: buffers producer bursts and
// hands the sender one byte per valid_send pulse, with a sticky overflow flag.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    input  logic [7:0]           wr_data,
    output logic                 wr_ready,
    output logic [DEPTH_LOG2:0]  count,
    output logic                 overflow,
    output logic                 valid_send,
    output logic [7:0]           data_send,
    input  logic                 ready_send
);

    tx_state_t  state_r;
    tx_state_t  state_next_s;
    logic       valid_send_r;
    logic       valid_send_next_s;
    logic [7:0] data_send_r;
    logic [7:0] data_send_next_s;
    logic       overflow_r;
    logic       pop_s;
    logic       full_s;
    logic       empty_s;
    logic [7:0] head_s;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_valid),
        .wr_data (wr_data),
        .pop     (pop_s),
        .rd_data (head_s),
        .count   (count),
        .full    (full_s),
        .empty   (empty_s)
    );

    // wr_ready depends on registered occupancy only, so a same-cycle pop never frees a slot.
    assign wr_ready   = !full_s;
    assign overflow   = overflow_r;
    assign valid_send = valid_send_r;
    assign data_send  = data_send_r;

    // Pacing decisions; HOLD masks the cycle in which the sender may still show ready.
    always_comb begin
        state_next_s      = state_r;
        valid_send_next_s = 1'b0;
        data_send_next_s  = data_send_r;
        pop_s             = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && ready_send) begin
                    valid_send_next_s = 1'b1;
                    data_send_next_s  = head_s;
                    pop_s             = 1'b1;
                    state_next_s      = SEND;
                end else begin
                    state_next_s      = IDLE;
                end
            end
            SEND:    state_next_s = HOLD;
            HOLD:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state and registered sender handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            valid_send_r <= 1'b0;
            data_send_r  <= 8'h00;
        end else begin
            state_r      <= state_next_s;
            valid_send_r <= valid_send_next_s;
            data_send_r  <= data_send_next_s;
        end
    end

    // Sticky record of any refused write.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer: reset, single byte, slow-sender burst,
// overflow, full-with-pop and reset mid-burst.
module tb_uart_tx_buffer;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [4:0] count;
    logic       overflow;
    logic       valid_send;
    logic [7:0] data_send;
    logic       ready_send;

    int checks;
    int errors;

    uart_tx_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .count      (count),
        .overflow   (overflow),
        .valid_send (valid_send),
        .data_send  (data_send),
        .ready_send (ready_send)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int  npulse;
        int  busy;
        bit  pend;
        bit  prev_v;
        int  nhigh;
        logic [7:0] last_data;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 8'h77;
        ready_send = 1'b1;

        // Reset held two cycles with wr_valid asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_count", 16'(count), 16'd0);
            check("rst_wr_ready", 16'(wr_ready), 16'd1);
            check("rst_valid", 16'(valid_send), 16'd0);
        end
        check("rst_overflow", 16'(overflow), 16'd0);
        check("rst_data", 16'(data_send), 16'h0000);
        rst      = 1'b0;
        wr_valid = 1'b0;
        step();
        check("rst_release_count", 16'(count), 16'd0);

        // Single byte: pulse two cycles after the push.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        step();
        wr_valid = 1'b0;
        check("single_count1", 16'(count), 16'd1);
        check("single_valid_early", 16'(valid_send), 16'd0);
        step();
        check("single_valid", 16'(valid_send), 16'd1);
        check("single_data", 16'(data_send), 16'h00A5);
        check("single_count0", 16'(count), 16'd0);
        nhigh = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid_send) nhigh++;
        end
        check("single_one_pulse", 16'(nhigh), 16'd0);
        check("single_data_stable", 16'(data_send), 16'h00A5);

        // Burst of 16 with the sender busy, then a slow sender.
        ready_send = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            step();
        end
        wr_valid = 1'b0;
        check("burst_count_full", 16'(count), 16'd16);
        check("burst_wr_ready_low", 16'(wr_ready), 16'd0);
        step();
        check("burst_wr_ready_still_low", 16'(wr_ready), 16'd0);
        ready_send = 1'b1;
        busy   = 0;
        pend   = 1'b0;
        npulse = 0;
        prev_v = 1'b0;
        for (int c = 0; c < 40000 && npulse < 16; c++) begin
            step();
            if (pend) begin
                ready_send = 1'b0;
                busy       = 1736;
                pend       = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) ready_send = 1'b1;
            end
            if (valid_send) begin
                check("burst_pulse_width", 16'(prev_v), 16'd0);
                check("burst_data", 16'(data_send), 16'(npulse));
                if (npulse == 0) check("burst_wr_ready_after_pop", 16'(wr_ready), 16'd1);
                npulse++;
                if (ready_send) pend = 1'b1;
            end
            prev_v = valid_send;
        end
        check("burst_npulse", 16'(npulse), 16'd16);
        check("burst_overflow", 16'(overflow), 16'd0);
        step();
        ready_send = 1'b0;
        step();
        check("burst_count_empty", 16'(count), 16'd0);

        // Overflow: 17 pushes with the sender not ready.
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + i);
            step();
        end
        wr_valid = 1'b0;
        check("ovf_count", 16'(count), 16'd16);
        check("ovf_flag", 16'(overflow), 16'd1);
        ready_send = 1'b1;
        npulse     = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (valid_send) begin
                check("ovf_data", 16'(data_send), 16'(8'h40 + npulse));
                npulse++;
            end
        end
        check("ovf_npulse", 16'(npulse), 16'd16);
        check("ovf_count_drained", 16'(count), 16'd0);
        check("ovf_sticky", 16'(overflow), 16'd1);

        // Full FIFO with a push in the pop cycle.
        ready_send = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        check("fullpop_overflow_cleared", 16'(overflow), 16'd0);
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h80 + i);
            step();
        end
        check("fullpop_count16", 16'(count), 16'd16);
        check("fullpop_no_ovf_yet", 16'(overflow), 16'd0);
        wr_data    = 8'hEE;
        ready_send = 1'b1;
        step();
        wr_valid   = 1'b0;
        ready_send = 1'b0;
        check("fullpop_count15", 16'(count), 16'd15);
        check("fullpop_overflow", 16'(overflow), 16'd1);
        check("fullpop_valid", 16'(valid_send), 16'd1);
        check("fullpop_data", 16'(data_send), 16'h0080);
        step();
        check("fullpop_count_hold", 16'(count), 16'd15);

        // Reset with five bytes queued, then a fresh byte.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hC0 + i);
            step();
        end
        wr_valid = 1'b0;
        check("midrst_count5", 16'(count), 16'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_count0", 16'(count), 16'd0);
        check("midrst_valid", 16'(valid_send), 16'd0);
        check("midrst_data", 16'(data_send), 16'h0000);
        check("midrst_overflow", 16'(overflow), 16'd0);
        ready_send = 1'b1;
        nhigh      = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_send) nhigh++;
        end
        check("midrst_no_pulse", 16'(nhigh), 16'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        step();
        wr_valid  = 1'b0;
        nhigh     = 0;
        last_data = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_send) begin
                nhigh++;
                last_data = data_send;
            end
        end
        check("midrst_new_pulse", 16'(nhigh), 16'd1);
        check("midrst_new_data", 16'(last_data), 16'h003C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and pacing controller sitting directly upstream of the UART `sender`. Core logic pushes bytes at full clock rate in bursts; the block stores them and feeds the sender one byte at a time through its `valid_send` / `data_send` / `ready_send` handshake. Without it, producers stall or drop bytes while the sender is busy, since one frame takes roughly 20 × CLK_PER_HALF_BIT cycles.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `clk` in 1: system clock from `clk_wiz`. Single clock domain; the sender runs on the same clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: producer presents a byte this cycle.
- `wr_data` in 8: byte to enqueue.
- `wr_ready` out 1: high when the FIFO is not full. A byte is accepted on a cycle with `wr_valid && wr_ready`.
- `count` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `overflow` out 1: sticky. Set on `wr_valid && !wr_ready`. Cleared only by `rst`.
- `valid_send` out 1: one-cycle pulse to the sender.
- `data_send` out 8: byte for the sender. Stable from the pulse until the next pulse.
- `ready_send` in 1: sender idle.

## Operation
- **Sender contract.** The sender latches `data_send` on a cycle with `valid_send && ready_send`, and drops `ready_send` no later than the following cycle.
- **FIFO.** Circular buffer with `rd_ptr` and `wr_ptr` of DEPTH_LOG2 bits each; both wrap modulo 2^DEPTH_LOG2.
  - `count` is updated each cycle as +1 (push only), −1 (pop only), or unchanged (both or neither).
  - full ⇔ `count == 2^DEPTH_LOG2`; empty ⇔ `count == 0`.
- **Write rules.**
  - `wr_ready = !full`, derived from the registered `count` only.
  - A push in the same cycle as a pop while full is rejected: `overflow` is set and the byte is dropped. There is no combinational pass-through from pop to `wr_ready`.
  - A push and pop in the same cycle when not full both occur.
- **FSM states: IDLE, SEND, HOLD.**
  - IDLE: if `!empty && ready_send`, then `data_send <= mem[rd_ptr]`, `valid_send <= 1`, pop, and go to SEND. Otherwise stay in IDLE with `valid_send <= 0`.
  - SEND: `valid_send` is high during this state. Set `valid_send <= 0` and go to HOLD.
  - HOLD: ignore `ready_send` for this cycle, then go to IDLE. This covers the sender's one-cycle delay in dropping `ready_send`.
- **Reset** (including mid-burst or mid-transfer):
  - `rd_ptr`, `wr_ptr`, `count` = 0; `overflow` = 0; `valid_send` = 0; `data_send` = 8'h00; state = IDLE.
  - FIFO contents are discarded, not cleared.
  - A frame already accepted by the sender is not cancelled.

## Timing
- **Reset values:** `wr_ready` = 1, `count` = 0, `overflow` = 0, `valid_send` = 0, `data_send` = 0.
- **First-byte latency:** byte pushed into an empty FIFO at cycle N, with FSM in IDLE and `ready_send` high → `valid_send` high at N+2.
  - Cycle N: write to memory.
  - Cycle N+1: IDLE sees `count` = 1 and makes the pop decision.
  - Cycle N+2: registered pulse.
- **Back-to-back spacing:** at least 3 cycles between pulses (SEND, HOLD, IDLE decision). In practice spacing is bounded by when `ready_send` returns.
- **`valid_send` width:** never high for more than one consecutive cycle.
- **Pointer/`count` visibility:** pointer and `count` updates are visible on the cycle after the push or pop edge. `wr_ready` falls on the cycle after the push that fills the FIFO.

## Structure
- **Package `uart_pkg`:**
  - FSM state typedef (`tx_state_t`: IDLE, SEND, HOLD).
  - Default `DEPTH_LOG2`.
  - `CLK_PER_HALF_BIT` default 868, shared with `receiver` and `sender`.
- **Sub-module `byte_fifo`:** synchronous FIFO with memory, pointers, count, full and empty.
- **`uart_tx_buffer` top:** `byte_fifo` instance plus the FSM and the overflow flag.
- **`test_loop` integration:** can insert this block before `sender` in place of the direct connection.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `wr_valid` = 1 → no pushes; `count` = 0, `wr_ready` = 1, `valid_send` = 0 throughout.
- **Single byte:** push 8'hA5 with `ready_send` held high → exactly one `valid_send` pulse 2 cycles later with `data_send` = 8'hA5; `count` returns to 0.
- **Burst with slow sender:**
  - Stimulus: push 8'h00..8'h0F at consecutive cycles. Sender model drops `ready_send` the cycle after accepting and restores it 1736 cycles later.
  - Required: 16 pulses in order 00..0F, `overflow` = 0, `wr_ready` low after the 16th push until the first pop.
- **Overflow:** with `ready_send` = 0, push 17 bytes → `count` = 16, `overflow` = 1, and the 17th byte never appears on `data_send`.
- **Full with simultaneous pop:** with the FIFO full, raise `ready_send` and push in the pop cycle → push rejected, `overflow` = 1, `count` = 15 next cycle.
- **Reset mid-burst:** with 5 bytes queued, assert `rst` for 1 cycle → `count` = 0, no further pulses; a new push of 8'h3C is sent as the next byte.
